mem_port_arbiter: RTL and testbench

- Shares one single-port backing memory between the instruction-fetch port (read-only) and the data port (load/store), replacing the separate private instruction and data memories.
- Grants at most one request per cycle with a data-priority policy and an anti-starvation counter for fetch.
- Tracks outstanding reads in an in-order owner FIFO and routes each memory response back to the port that issued it.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the shared backing memory.
// The arbiter uses the slave view; the surrounding system (core + memory) uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_ready;
  logic                  m_rvalid;
  logic [DATA_W-1:0]     m_rdata;

  logic                  err;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rvalid, m_rdata,
    output err
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rvalid, m_rdata,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access: data-priority
// arbitration with fetch anti-starvation, and an in-order owner FIFO that routes read responses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W    = $clog2(MAX_OUT + 1);
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(MAX_OUT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [MAX_OUT-1:0]  owner_reg, owner_next, owner_we;
  logic [STARVE_W-1:0] starve_reg, starve_next;

  logic                i_rvalid_reg, d_rvalid_reg, err_reg;
  logic [DATA_W-1:0]   i_rdata_reg, d_rdata_reg;

  logic slot_ok, fetch_wins, i_gnt_w, d_gnt_w;
  logic push, pop, stray, head;

  // Pointers wrap explicitly so non-power-of-two and depth-1 FIFOs also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A response popping this cycle frees a slot for a request granted in the same cycle.
  always_comb begin
    slot_ok    = bus.m_ready & ((count_reg < CNT_MAX) | bus.m_rvalid);
    fetch_wins = bus.i_req & (~bus.d_req | (starve_reg == STARVE_MAX));
    i_gnt_w    = ~rst & slot_ok & fetch_wins;
    d_gnt_w    = ~rst & slot_ok & bus.d_req & ~fetch_wins;
    push       = i_gnt_w | (d_gnt_w & ~bus.d_we);
    pop        = bus.m_rvalid & (count_reg != '0);
    stray      = bus.m_rvalid & (count_reg == '0);
    head       = owner_reg[rd_ptr_reg];
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    starve_next = starve_reg;
    if (!bus.i_req || i_gnt_w) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_next = starve_reg + STARVE_W'(1);
    end
  end

  // Owner entry: 0 = fetch issued the read, 1 = data port issued it.
  for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_owner
    assign owner_we[gi]   = push & (wr_ptr_reg == PTR_W'(gi));
    assign owner_next[gi] = owner_we[gi] ? d_gnt_w : owner_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      owner_reg  <= '0;
      starve_reg <= '0;
    end else begin
      count_reg  <= count_next;
      owner_reg  <= owner_next;
      starve_reg <= starve_next;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  // Responses with no owner are dropped and flagged; they never reach a port.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      i_rvalid_reg <= pop & ~head;
      d_rvalid_reg <= pop & head;
      if (pop && !head) begin
        i_rdata_reg <= bus.m_rdata;
      end
      if (pop && head) begin
        d_rdata_reg <= bus.m_rdata;
      end
      err_reg <= err_reg | stray;
    end
  end

  assign bus.i_gnt    = i_gnt_w;
  assign bus.d_gnt    = d_gnt_w;
  assign bus.i_rvalid = i_rvalid_reg;
  assign bus.i_rdata  = i_rdata_reg;
  assign bus.d_rvalid = d_rvalid_reg;
  assign bus.d_rdata  = d_rdata_reg;
  assign bus.err      = err_reg;

  assign bus.m_req   = i_gnt_w | d_gnt_w;
  assign bus.m_we    = d_gnt_w & bus.d_we;
  assign bus.m_addr  = i_gnt_w ? bus.i_addr : (d_gnt_w ? bus.d_addr : '0);
  assign bus.m_wdata = d_gnt_w ? bus.d_wdata : '0;
  assign bus.m_wstrb = d_gnt_w ? bus.d_wstrb : STRB_W'(0);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int MOUT  = 2;
  localparam int SLIM  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MOUT), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic drive(input logic ireq, input logic [AW-1:0] iaddr,
                       input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] dwdata, input logic [SW-1:0] dwstrb,
                       input logic mready, input logic mrvalid, input logic [DW-1:0] mrdata);
    bus.i_req = ireq;  bus.i_addr = iaddr;
    bus.d_req = dreq;  bus.d_we = dwe;  bus.d_addr = daddr;
    bus.d_wdata = dwdata;  bus.d_wstrb = dwstrb;
    bus.m_ready = mready;  bus.m_rvalid = mrvalid;  bus.m_rdata = mrdata;
  endtask

  task automatic idle(input logic mrvalid, input logic [DW-1:0] mrdata);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, mrvalid, mrdata);
  endtask

  task automatic fetch_req(input logic [AW-1:0] a, input logic mrvalid, input logic [DW-1:0] mrdata);
    drive(1'b1, a, 1'b0, 1'b0, '0, '0, '0, 1'b1, mrvalid, mrdata);
  endtask

  task automatic load_req(input logic [AW-1:0] a, input logic mready, input logic mrvalid,
                          input logic [DW-1:0] mrdata);
    drive(1'b0, '0, 1'b1, 1'b0, a, '0, '0, mready, mrvalid, mrdata);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b0) begin fails++; $display("FAIL reset.i_gnt got %0h want 0", bus.i_gnt); end
    checks++; if (bus.d_gnt !== 1'b0) begin fails++; $display("FAIL reset.d_gnt got %0h want 0", bus.d_gnt); end
    checks++; if (bus.m_req !== 1'b0) begin fails++; $display("FAIL reset.m_req got %0h want 0", bus.m_req); end
    cyc();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL reset.rvalid got %0b%0b want 00", bus.i_rvalid, bus.d_rvalid); end
    checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin fails++; $display("FAIL reset.rdata got %h/%h want 0/0", bus.i_rdata, bus.d_rdata); end
    checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset.err got %0h want 0", bus.err); end
    rst = 1'b0;
    idle(1'b0, '0);
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_fetch_only();
    fetch_req(32'h0040_0000, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin fails++; $display("FAIL fetch.gnt got i%0b d%0b want i1 d0", bus.i_gnt, bus.d_gnt); end
    checks++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b0 || bus.m_addr !== 32'h0040_0000) begin fails++; $display("FAIL fetch.mem got req%0b we%0b addr %h want req1 we0 addr 00400000", bus.m_req, bus.m_we, bus.m_addr); end
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0) begin fails++; $display("FAIL fetch.early_rvalid got %0b want 0", bus.i_rvalid); end
    cyc();
    idle(1'b1, 32'h0000_0013);
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_0013) begin fails++; $display("FAIL fetch.resp got v%0b %h want v1 00000013", bus.i_rvalid, bus.i_rdata); end
    checks++; if (bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL fetch.d_rvalid got %0b want 0", bus.d_rvalid); end
    cyc();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0000_0013) begin fails++; $display("FAIL fetch.hold got v%0b %h want v0 00000013", bus.i_rvalid, bus.i_rdata); end
    cyc();
    $display("test_fetch_only done");
  endtask

  task automatic test_starvation();
    logic exp_i;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, '0);
      exp_i = (k == 5);
      @(negedge clk);
      checks++;
      if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
        fails++; $display("FAIL starve.cycle%0d got i%0b d%0b want i%0b d%0b", k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i);
      end
      if (exp_i) begin
        checks++;
        if (bus.m_addr !== 32'h0040_0100 || bus.m_we !== 1'b0 || bus.m_wdata !== '0 || bus.m_wstrb !== '0) begin
          fails++; $display("FAIL starve.fetch_mux got addr %h we%0b wd %h ws %h want 00400100 0 0 0", bus.m_addr, bus.m_we, bus.m_wdata, bus.m_wstrb);
        end
      end
      cyc();
    end
    idle(1'b1, 32'h0000_0055);
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_0055) begin fails++; $display("FAIL starve.resp got v%0b %h want v1 00000055", bus.i_rvalid, bus.i_rdata); end
    cyc();
    $display("test_starvation done");
  endtask

  task automatic test_full_fifo();
    load_req(32'h0000_1000, 1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b0 || bus.m_req !== 1'b0) begin fails++; $display("FAIL full.not_ready got d%0b m%0b want 0 0", bus.d_gnt, bus.m_req); end
    cyc();
    load_req(32'h0000_1000, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL full.first got %0b want 1", bus.d_gnt); end
    cyc();
    load_req(32'h0000_1004, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL full.second got %0b want 1", bus.d_gnt); end
    cyc();
    fetch_req(32'h0040_0200, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b0 || bus.m_req !== 1'b0) begin fails++; $display("FAIL full.blocked got i%0b m%0b want 0 0", bus.i_gnt, bus.m_req); end
    cyc();
    fetch_req(32'h0040_0200, 1'b1, 32'h0000_0111);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1) begin fails++; $display("FAIL full.pop_frees got %0b want 1", bus.i_gnt); end
    cyc();
    load_req(32'h0000_1008, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b0) begin fails++; $display("FAIL full.count_stays got %0b want 0", bus.d_gnt); end
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0000_0111) begin fails++; $display("FAIL full.resp1 got v%0b %h want v1 00000111", bus.d_rvalid, bus.d_rdata); end
    cyc();
    idle(1'b1, 32'h0000_0222);
    cyc();
    idle(1'b1, 32'h0000_0333);
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0000_0222) begin fails++; $display("FAIL full.resp2 got v%0b %h want v1 00000222", bus.d_rvalid, bus.d_rdata); end
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_0333 || bus.err !== 1'b0) begin fails++; $display("FAIL full.resp3 got v%0b %h err%0b want v1 00000333 err0", bus.i_rvalid, bus.i_rdata, bus.err); end
    cyc();
    $display("test_full_fifo done");
  endtask

  task automatic test_interleaved();
    fetch_req(32'h0040_0300, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1) begin fails++; $display("FAIL inter.f1 got %0b want 1", bus.i_gnt); end
    cyc();
    load_req(32'h0000_2000, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL inter.l1 got %0b want 1", bus.d_gnt); end
    cyc();
    fetch_req(32'h0040_0304, 1'b1, 32'h0000_000A);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1) begin fails++; $display("FAIL inter.f2 got %0b want 1", bus.i_gnt); end
    cyc();
    idle(1'b1, 32'h0000_000B);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_000A || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL inter.rA got iv%0b %h dv%0b want 1 0000000a 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid); end
    cyc();
    idle(1'b1, 32'h0000_000C);
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0000_000B || bus.i_rvalid !== 1'b0) begin fails++; $display("FAIL inter.rB got dv%0b %h iv%0b want 1 0000000b 0", bus.d_rvalid, bus.d_rdata, bus.i_rvalid); end
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_000C || bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0000_000B) begin fails++; $display("FAIL inter.rC got iv%0b %h dv%0b %h want 1 0000000c 0 0000000b", bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata); end
    cyc();
    $display("test_interleaved done");
  endtask

  task automatic test_write();
    drive(1'b0, '0, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1 || bus.m_req !== 1'b1 || bus.m_we !== 1'b1) begin fails++; $display("FAIL write.gnt got d%0b req%0b we%0b want 1 1 1", bus.d_gnt, bus.m_req, bus.m_we); end
    checks++; if (bus.m_addr !== 32'h1001_0004 || bus.m_wdata !== 32'hDEAD_BEEF || bus.m_wstrb !== 4'b0011) begin fails++; $display("FAIL write.pass got %h %h %b want 10010004 deadbeef 0011", bus.m_addr, bus.m_wdata, bus.m_wstrb); end
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL write.no_resp got %0b%0b want 00", bus.i_rvalid, bus.d_rvalid); end
    cyc();
    load_req(32'h0000_3000, 1'b1, 1'b0, '0);
    cyc();
    load_req(32'h0000_3004, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL write.second_load got %0b want 1", bus.d_gnt); end
    cyc();
    fetch_req(32'h0040_0400, 1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b0) begin fails++; $display("FAIL write.count got %0b want 0", bus.i_gnt); end
    cyc();
    idle(1'b1, 32'h0000_0001);
    cyc();
    idle(1'b1, 32'h0000_0002);
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.err !== 1'b0 || bus.d_rdata !== 32'h0000_0002) begin fails++; $display("FAIL write.drain got err%0b %h want 0 00000002", bus.err, bus.d_rdata); end
    cyc();
    $display("test_write done");
  endtask

  task automatic test_reset_stale();
    fetch_req(32'h0040_0500, 1'b0, '0);
    cyc();
    load_req(32'h0000_4000, 1'b1, 1'b0, '0);
    cyc();
    rst = 1'b1;
    idle(1'b0, '0);
    cyc();
    rst = 1'b0;
    idle(1'b1, 32'h0000_0099);
    cyc();
    idle(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL stale.rvalid got %0b%0b want 00", bus.i_rvalid, bus.d_rvalid); end
    checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL stale.err got %0b want 1", bus.err); end
    cyc();
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL stale.sticky got %0b want 1", bus.err); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL stale.clear got %0b want 0", bus.err); end
    cyc();
    $display("test_reset_stale done");
  endtask

  task automatic test_random();
    bit              owners[$];
    int              starve = 0;
    logic            exp_irv = 1'b0, exp_drv = 1'b0, exp_err = 1'b0;
    logic [DW-1:0]   exp_ird = '0, exp_drd = '0;
    logic            ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mready, mrvalid;
    logic [AW-1:0]   iaddr = '0, daddr = '0;
    logic [DW-1:0]   dwdata = '0, mrdata;
    logic [SW-1:0]   dwstrb = '0;
    bit              i_pend = 0, d_pend = 0, slot, fw, egi, egd, o;
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [SW-1:0]   e_wstrb;
    int              errs_before = fails;

    rst = 1'b1;
    idle(1'b0, '0);
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_pend) begin
        ireq = ($urandom_range(0, 2) != 0);
        iaddr = {$urandom()} & 32'hFFFF_FFFC;
      end
      if (!d_pend) begin
        dreq = ($urandom_range(0, 2) != 0);
        dwe = $urandom_range(0, 1) != 0;
        daddr = $urandom();
        dwdata = $urandom();
        dwstrb = SW'($urandom_range(0, 15));
      end
      mready = ($urandom_range(0, 3) != 0);
      mrvalid = (owners.size() > 0) && ($urandom_range(0, 1) != 0);
      mrdata = $urandom();
      drive(ireq, iaddr, dreq, dwe, daddr, dwdata, dwstrb, mready, mrvalid, mrdata);

      slot = mready && (owners.size() < MOUT || mrvalid);
      fw   = ireq && (!dreq || starve == SLIM);
      egi  = slot && fw;
      egd  = slot && dreq && !fw;
      e_we = egd && dwe;
      e_addr = egi ? iaddr : (egd ? daddr : '0);
      e_wdata = egd ? dwdata : '0;
      e_wstrb = egd ? dwstrb : '0;

      @(negedge clk);
      checks++;
      if (bus.i_gnt !== egi || bus.d_gnt !== egd || bus.m_req !== (egi || egd)) begin
        fails++; $display("FAIL rand.gnt cyc%0d got i%0b d%0b m%0b want i%0b d%0b", n, bus.i_gnt, bus.d_gnt, bus.m_req, egi, egd);
      end
      checks++;
      if (bus.m_we !== e_we || bus.m_addr !== e_addr || bus.m_wdata !== e_wdata || bus.m_wstrb !== e_wstrb) begin
        fails++; $display("FAIL rand.mem cyc%0d got we%0b %h %h %h want we%0b %h %h %h", n, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb, e_we, e_addr, e_wdata, e_wstrb);
      end
      checks++;
      if (bus.i_rvalid !== exp_irv || bus.i_rdata !== exp_ird || bus.d_rvalid !== exp_drv || bus.d_rdata !== exp_drd || bus.err !== exp_err) begin
        fails++; $display("FAIL rand.resp cyc%0d got i%0b %h d%0b %h e%0b want i%0b %h d%0b %h e%0b", n, bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, bus.err, exp_irv, exp_ird, exp_drv, exp_drd, exp_err);
      end

      exp_irv = 1'b0;
      exp_drv = 1'b0;
      if (mrvalid) begin
        if (owners.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          o = owners.pop_front();
          if (o) begin exp_drv = 1'b1; exp_drd = mrdata; end
          else begin exp_irv = 1'b1; exp_ird = mrdata; end
        end
      end
      if (egi) owners.push_back(1'b0);
      else if (egd && !dwe) owners.push_back(1'b1);
      if (!ireq || egi) starve = 0;
      else if (starve < SLIM) starve++;
      i_pend = ireq && !egi;
      d_pend = dreq && !egd;
      cyc();
    end
    $display("test_random done: %0d new failures", fails - errs_before);
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0, '0);
    test_reset();
    test_fetch_only();
    test_starvation();
    test_full_fifo();
    test_interleaved();
    test_write();
    test_reset_stale();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
